mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences all accesses to the single-ported data memory (`Mem`) in the multi-cycle MIPS core and shares it between two requesters. The requesters are the instruction-fetch port (read-only) and the load/store data port. It sits between the control unit's fetch/memory stages and `Mem`. It drives `Mem`'s read/write strobes from registers so each access occupies exactly one memory clock cycle, and it returns read data through per-port done handshakes.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words in the attached memory; valid byte addresses are 0 to 4*DEPTH-4.

Ports:
- clock_in, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_req, input, 1: fetch read request; held until i_done.
- i_addr, input, 32: fetch byte address.
- i_rdata, output, 32: fetch read data.
- i_done, output, 1: one-cycle completion pulse for the fetch port.
- d_req, input, 1: data request; held until d_done.
- d_we, input, 1: 1 = store, 0 = load.
- d_addr, input, 32: data byte address.
- d_wdata, input, 32: store data.
- d_rdata, output, 32: load data.
- d_done, output, 1: one-cycle completion pulse for the data port.
- err, output, 1: qualifies the done pulse of the same cycle; the access was rejected.
- busy, output, 1: high whenever the FSM is not IDLE.
- mem_addr, output, 32: to Mem addr.
- mem_wdata, output, 32: to Mem writeData.
- mem_read, output, 1: to Mem memRead.
- mem_write, output, 1: to Mem memWrite.
- mem_rdata, input, 32: from Mem readData.

## Operation
- **FSM states:** IDLE, ACCESS, RESP. All outputs are registered.
- **IDLE:**
  - If any request is pending, select an owner and latch the owner, address, we and wdata.
  - Legal address (addr[1:0]==0 and addr < 4*DEPTH): go to ACCESS.
  - Illegal address: go to RESP with the error flag set; no memory strobe is issued.
  - No request pending: stay in IDLE.
- **ACCESS:**
  - mem_addr is the latched address.
  - For a load or fetch, mem_read=1. For a store, mem_write=1 and mem_wdata = latched wdata.
  - Exactly one strobe is high, for exactly one cycle. Mem acts on the falling edge inside this cycle.
  - At the closing rising edge, for a read, mem_rdata is captured into the owner's rdata register. Then go to RESP.
- **RESP:**
  - Owner's done=1 for one cycle; err=1 only if rejected. Strobes are 0.
  - On a rejected or write access, rdata is left unchanged.
  - Next state is always IDLE.
- **Data retention:** i_rdata and d_rdata hold their value until the next successful read by the same port.
- **Request handshake:**
  - Requesters must hold req, addr, we and wdata stable from assertion until done.
  - A req still high in the cycle after done is treated as a new request.
  - The fetch port never writes.
- **Arbitration:** applies when both i_req and d_req are high in IDLE; see Configuration. A single requester is always granted.
- **Simultaneous arrival:** a request arriving while busy waits in IDLE for evaluation; requests are never dropped.

## Timing
- **Reset values:** FSM = IDLE, all outputs 0 (rdata registers, done, err, busy, all mem_* signals), last-owner = fetch.
- **Latency:** req sampled at edge k (IDLE). ACCESS is cycle k..k+1; done is high in cycle k+1..k+2.
  - A legal access returns done 2 cycles after grant.
  - A rejected access returns done 1 cycle after grant.
- **Throughput:** at most one access per 3 cycles, because the FSM returns to IDLE for one cycle between accesses.
- **Reset mid-operation:** the next edge with rst=1 forces IDLE and clears all outputs; no done is issued for the in-flight access.
  - A store whose ACCESS falling edge already occurred stays written. Otherwise it is not written.

## Configuration
- **MEM_ARB_RR_EN defined:** round-robin arbitration.
  - On conflict, the port not granted last wins; last-owner updates on every grant.
  - After reset the data port wins the first conflict.
- **MEM_ARB_RR_EN undefined:** fixed priority; the data port always wins conflicts. The last-owner register is removed.

## Test plan
- **Fetch read:** preload word 3 = 0x1234_5678; i_req=1 with i_addr=0x0C. Required: mem_read high for exactly one cycle with mem_addr=0x0C; i_done high 2 cycles after grant with i_rdata=0x1234_5678 and err=0.
- **Store then load:** d_we=1, d_addr=0x20, d_wdata=0xDEAD_BEEF, then a load from 0x20. Required: one mem_write pulse, then d_rdata=0xDEAD_BEEF; i_rdata unchanged.
- **Conflict:** i_req and d_req held high continuously for 4 accesses.
  - With MEM_ARB_RR_EN, grants are D, I, D, I.
  - Without it, grants are D, D, D, D while d_req stays high.
- **Illegal addresses:** d_addr=0x102 (misaligned), then d_addr=0x100 with DEPTH=64.
  - Required: d_done and err high 1 cycle after grant; mem_read and mem_write never asserted; d_rdata unchanged.
- **Reset mid-access:** assert rst during ACCESS of a load. Required: next cycle is IDLE with all outputs 0, no d_done pulse, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter/sequencer for single-ported Mem; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_own_d;
  logic        r_we;
  logic        w_pending;
  logic        w_grant_d;
  logic        w_sel_we;
  logic        w_legal;
  logic [31:0] w_sel_addr;

  assign w_pending = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // last_d=0 (fetch) after reset, so the data port wins the first conflict
  always_ff @(posedge clock_in) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && w_pending) begin
      r_last_d <= w_grant_d;
    end
  end

  assign w_grant_d = d_req & (~i_req | ~r_last_d);
`else
  assign w_grant_d = d_req;
`endif

  assign w_sel_addr = w_grant_d ? d_addr : i_addr;
  assign w_sel_we   = w_grant_d & d_we;
  assign w_legal    = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr < 32'(4 * DEPTH));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pending) w_state_next = w_legal ? S_ACCESS : S_RESP;
      S_ACCESS: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs are registered from the upcoming state so strobes align with ACCESS
  always_ff @(posedge clock_in) begin
    if (rst) begin
      r_own_d   <= 1'b0;
      r_we      <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pending) begin
            r_own_d <= w_grant_d;
            r_we    <= w_sel_we;
            if (w_legal) begin
              mem_addr  <= w_sel_addr;
              mem_read  <= ~w_sel_we;
              mem_write <= w_sel_we;
              mem_wdata <= w_sel_we ? d_wdata : 32'h0;
            end else begin
              i_done <= ~w_grant_d;
              d_done <= w_grant_d;
              err    <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          i_done <= ~r_own_d;
          d_done <= r_own_d;
          if (!r_we) begin
            if (r_own_d) d_rdata <= mem_rdata;
            else         i_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a memory reference
module tb_mem_port_arbiter;

  logic        clock_in = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [64];
  logic [31:0] ref_mem [64];
  int          n_reads = 0;
  int          n_writes = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  mem_port_arbiter #(.DEPTH(64)) dut (
    .clock_in(clock_in), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clock_in = ~clock_in;

  // Mem itself: acts on the falling edge while a strobe is high
  always @(negedge clock_in) begin
    if (mem_read || mem_write) begin
      last_addr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_read) begin
      n_reads++;
      mem_rdata = (mem_addr < 32'd256) ? model_mem[mem_addr[7:2]] : 32'hBAD0_BAD0;
    end
    if (mem_write) begin
      n_writes++;
      if (mem_addr < 32'd256) model_mem[mem_addr[7:2]] = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic pd, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic legal;
    logic got;
    int   cyc;
    int   r0;
    int   w0;
    legal = (addr[1:0] == 2'b00) && (addr < 32'd256);
    r0 = n_reads;
    w0 = n_writes;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      tick();
      cyc++;
      got = pd ? d_done : i_done;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), legal ? 32'd2 : 32'd1);
    check("err", 32'(err), 32'(!legal));
    check("other_done", 32'(pd ? i_done : d_done), 32'd0);
    check("resp_state", 32'({busy, mem_read, mem_write}), 32'b100);
    if (legal && we) ref_mem[addr[7:2]] = wd;
    if (legal && !we) begin
      if (pd) exp_d = ref_mem[addr[7:2]];
      else    exp_i = ref_mem[addr[7:2]];
    end
    check("read_strobes", 32'(n_reads - r0), 32'(legal && !we));
    check("write_strobes", 32'(n_writes - w0), 32'(legal && we));
    if (legal) check("strobe_addr", last_addr, addr);
    if (legal && we) check("strobe_wdata", last_wdata, wd);
    check("i_rdata", i_rdata, exp_i);
    check("d_rdata", d_rdata, exp_d);
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    tick();
    check("back_idle", 32'({busy, i_done, d_done, err}), 32'd0);
  endtask

  initial begin
    logic        pd;
    logic        we;
    logic [31:0] addr;
    int          sel;
    logic        got;
    int          cyc;
    logic        exp_grant_d;

    for (int k = 0; k < 64; k++) begin
      model_mem[k] = $urandom;
      ref_mem[k] = model_mem[k];
    end
    model_mem[3] = 32'h1234_5678;
    ref_mem[3] = 32'h1234_5678;

    tick(); tick(); tick();
    check("reset_rdata", i_rdata | d_rdata, 32'd0);
    check("reset_mem_bus", mem_addr | mem_wdata, 32'd0);
    check("reset_flags", 32'({i_done, d_done, err, busy, mem_read, mem_write}), 32'd0);
    rst = 1'b0;
    tick();

    access(1'b0, 1'b0, 32'h0000_000C, 32'h0);
    access(1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    check("store_load_value", d_rdata, 32'hDEAD_BEEF);
    check("fetch_kept", i_rdata, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h0000_0102, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    access(1'b1, 1'b0, 32'h0000_00FC, 32'h0);

    for (int n = 0; n < 40; n++) begin
      pd = 1'($urandom_range(0, 1));
      we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      addr = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      else if (sel == 1) addr = 32'(256 + 4 * $urandom_range(0, 1000));
      else if (sel == 2) addr = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
      else               addr = 32'(4 * $urandom_range(0, 63));
      access(pd, we, addr, $urandom);
    end

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_000C;
    tick();
    check("rst_mid_strobe", 32'({busy, mem_read}), 32'b11);
    rst = 1'b1;
    tick();
    check("rst_mid_rdata", i_rdata | d_rdata, 32'd0);
    check("rst_mid_bus", mem_addr | mem_wdata, 32'd0);
    check("rst_mid_flags", 32'({i_done, d_done, err, busy, mem_read, mem_write}), 32'd0);
    d_req = 1'b0;
    rst = 1'b0;
    exp_i = '0;
    exp_d = '0;
    tick();
    check("rst_mid_no_done", 32'({d_done, i_done, busy}), 32'd0);
    tick();

    i_req = 1'b1; i_addr = 32'h0000_000C;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_grant_d = (k % 2 == 0);
`else
      exp_grant_d = 1'b1;
`endif
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 8) begin
        tick();
        cyc++;
        got = i_done | d_done;
      end
      check("conflict_done", 32'(got), 32'd1);
      check("conflict_grant", 32'({d_done, i_done}), exp_grant_d ? 32'b10 : 32'b01);
      if (exp_grant_d) exp_d = ref_mem[8];
      else             exp_i = ref_mem[3];
      check("conflict_i_rdata", i_rdata, exp_i);
      check("conflict_d_rdata", d_rdata, exp_d);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    check("final_idle", 32'({busy, i_done, d_done}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
